spi_master: RTL and testbench

Byte-wide SPI mode-0 master that sits directly downstream of the memory controller. It shifts one byte out on MOSI while shifting one byte in from MISO for each `txn_start` request, and reports completion on `txn_done`. It also generates a standalone SCLK pulse on request, used as the dummy clock between chip-select changes. It drives the flash/RAM SCLK and MOSI pins; chip-selects are owned upstream.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_master_if.sv | 24 ++
 rtl/spi_clk_div.sv | 30 +++
 rtl/spi_master.sv | 132 +++++++++++++
 tb/tb_spi_master.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the byte-wide SPI mode-0 master.
package spi_pkg;

    localparam int SPI_BITS  = 8;
    localparam int SPI_DIV_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_FORCE_HI = 3'd3,
        ST_FORCE_LO = 3'd4
    } spi_state_t;

endpackage

// File: rtl/spi_master_if.sv
// Upstream request/response and SPI pin bundle of spi_master.
interface spi_master_if;
    import spi_pkg::*;

    logic [SPI_BITS-1:0] data_tx;
    logic [SPI_BITS-1:0] data_rx;
    logic                txn_start;
    logic                txn_done;
    logic                force_clock;
    logic                sclk;
    logic                mosi;
    logic                miso;

    modport master (
        input  data_tx, txn_start, force_clock, miso,
        output data_rx, txn_done, sclk, mosi
    );

    modport slave (
        output data_tx, txn_start, force_clock, miso,
        input  data_rx, txn_done, sclk, mosi
    );

endinterface

// File: rtl/spi_clk_div.sv
// SCLK phase timer: phase_end pulses for one cycle every CLK_DIV cycles,
// restarting from zero whenever clear is asserted.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 1
)(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic phase_end
);

    localparam logic [SPI_DIV_W-1:0] LAST = SPI_DIV_W'(CLK_DIV - 1);

    logic [SPI_DIV_W-1:0] r_cnt;

    assign phase_end = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || phase_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Byte-wide SPI mode-0 master with a standalone dummy SCLK pulse.
// Define SPI_MISO_LATE_SAMPLE_EN to sample MISO on the SCLK falling transition.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 1
)(
    input  logic         clk,
    input  logic         rst_n,
    spi_master_if.master bus
);

    localparam logic [2:0] LAST_BIT = 3'(SPI_BITS - 1);

    spi_state_t          r_state, w_state_next;
    logic [SPI_BITS-1:0] r_shift, w_shift_next;
    logic [SPI_BITS-1:0] r_rx_shift, w_rx_shift_next;
    logic [SPI_BITS-1:0] r_data_rx, w_data_rx_next;
    logic [SPI_BITS-1:0] w_rx_byte;
    logic [2:0]          r_bit_cnt, w_bit_cnt_next;
    logic                r_sclk, w_sclk_next;
    logic                r_done, w_done_next;
    logic                w_phase_end;
    logic                w_clear;

    assign w_clear = (w_state_next != r_state);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_clear),
        .phase_end (w_phase_end)
    );

    // Byte as it stands at the falling transition that ends a bit.
`ifdef SPI_MISO_LATE_SAMPLE_EN
    assign w_rx_byte = {r_rx_shift[SPI_BITS-2:0], bus.miso};
`else
    assign w_rx_byte = r_rx_shift;
`endif

    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_rx_shift_next = r_rx_shift;
        w_data_rx_next  = r_data_rx;
        w_bit_cnt_next  = r_bit_cnt;
        w_sclk_next     = r_sclk;
        w_done_next     = r_done;
        case (r_state)
            ST_IDLE: begin
                if (bus.txn_start) begin
                    w_shift_next   = bus.data_tx;
                    w_bit_cnt_next = '0;
                    w_done_next    = 1'b0;
                    w_state_next   = ST_SHIFT_LO;
                end else if (bus.force_clock) begin
                    w_sclk_next  = 1'b1;
                    w_state_next = ST_FORCE_HI;
                end
            end
            ST_SHIFT_LO: begin
                if (w_phase_end) begin
                    w_sclk_next  = 1'b1;
                    w_state_next = ST_SHIFT_HI;
`ifndef SPI_MISO_LATE_SAMPLE_EN
                    w_rx_shift_next = {r_rx_shift[SPI_BITS-2:0], bus.miso};
`endif
                end
            end
            ST_SHIFT_HI: begin
                if (w_phase_end) begin
                    w_sclk_next     = 1'b0;
                    w_rx_shift_next = w_rx_byte;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_data_rx_next = w_rx_byte;
                        w_done_next    = 1'b1;
                        w_bit_cnt_next = '0;
                        w_state_next   = ST_IDLE;
                    end else begin
                        // MOSI is the shift register MSB, so shifting presents the next bit.
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                        w_shift_next   = {r_shift[SPI_BITS-2:0], 1'b0};
                        w_state_next   = ST_SHIFT_LO;
                    end
                end
            end
            ST_FORCE_HI: begin
                if (w_phase_end) begin
                    w_sclk_next  = 1'b0;
                    w_state_next = ST_FORCE_LO;
                end
            end
            ST_FORCE_LO: begin
                if (w_phase_end) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_sclk_next  = 1'b0;
                w_done_next  = 1'b1;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_rx_shift <= '0;
            r_data_rx  <= '0;
            r_bit_cnt  <= '0;
            r_sclk     <= 1'b0;
            r_done     <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_rx_shift <= w_rx_shift_next;
            r_data_rx  <= w_data_rx_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_sclk     <= w_sclk_next;
            r_done     <= w_done_next;
        end
    end

    assign bus.sclk     = r_sclk;
    assign bus.mosi     = r_shift[SPI_BITS-1];
    assign bus.txn_done = r_done;
    assign bus.data_rx  = r_data_rx;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: CLK_DIV=1 and CLK_DIV=3 instances with SPI slave models.
module tb_spi_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Index 0 drives the CLK_DIV=1 instance, index 1 the CLK_DIV=3 instance.
    logic       t_sclk [2];
    logic       t_mosi [2];
    logic       t_done [2];
    logic [7:0] t_rx   [2];
    logic       t_start[2];
    logic       t_force[2];
    logic [7:0] t_tx   [2];
    logic       s_miso [2];
    logic [7:0] s_byte [2];
    logic [7:0] s_cap  [2];
    int         s_idx  [2];
    int         s_rises[2];
    int         s_high [2];
    int         tot_rises[2];
    logic       p_sclk [2];
    logic       p_done [2];

    spi_master_if bus1();
    spi_master_if bus3();

    spi_master #(.CLK_DIV(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    spi_master #(.CLK_DIV(3)) u_d3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    assign t_sclk[0] = bus1.sclk;      assign t_sclk[1] = bus3.sclk;
    assign t_mosi[0] = bus1.mosi;      assign t_mosi[1] = bus3.mosi;
    assign t_done[0] = bus1.txn_done;  assign t_done[1] = bus3.txn_done;
    assign t_rx[0]   = bus1.data_rx;   assign t_rx[1]   = bus3.data_rx;
    assign bus1.txn_start   = t_start[0]; assign bus3.txn_start   = t_start[1];
    assign bus1.force_clock = t_force[0]; assign bus3.force_clock = t_force[1];
    assign bus1.data_tx     = t_tx[0];    assign bus3.data_tx     = t_tx[1];
    assign bus1.miso        = s_miso[0];  assign bus3.miso        = s_miso[1];

    typedef struct {
        logic [7:0] rx;
        logic [7:0] mosi;
        int         busy;
        int         high;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [7:0] tx;
        logic [7:0] slv;
        logic       frc;
    } vec_t;
    vec_t vecs[6];

    int n_checks = 0;
    int n_pass   = 0;

    // Slave models and pin monitor, evaluated on the falling clk edge.
    initial begin
        for (int k = 0; k < 2; k++) begin
            s_miso[k] = 1'b0; s_byte[k] = 8'h00; s_cap[k] = 8'h00; s_idx[k] = 7;
            s_rises[k] = 0; s_high[k] = 0; tot_rises[k] = 0; p_sclk[k] = 1'b0; p_done[k] = 1'b1;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (p_done[k] === 1'b1 && t_done[k] === 1'b0) begin
                s_idx[k] = 7; s_cap[k] = 8'h00; s_rises[k] = 0; s_high[k] = 0;
`ifdef SPI_MISO_LATE_SAMPLE_EN
                s_miso[k] = ~s_byte[k][7];
`endif
            end
            if (t_done[k] === 1'b0 && t_sclk[k] === 1'b1) s_high[k]++;
            if (p_sclk[k] === 1'b0 && t_sclk[k] === 1'b1) begin
                tot_rises[k]++;
                if (t_done[k] === 1'b0) begin
                    s_cap[k] = {s_cap[k][6:0], t_mosi[k]};
                    s_rises[k]++;
`ifdef SPI_MISO_LATE_SAMPLE_EN
                    if (s_rises[k] <= 8) s_miso[k] = s_byte[k][8 - s_rises[k]];
`endif
                end
            end
`ifndef SPI_MISO_LATE_SAMPLE_EN
            if (p_sclk[k] === 1'b1 && t_sclk[k] === 1'b0 && t_done[k] === 1'b0 && s_idx[k] > 0)
                s_idx[k]--;
            s_miso[k] = s_byte[k][s_idx[k]];
`endif
            p_sclk[k] = t_sclk[k];
            p_done[k] = t_done[k];
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_reset_vals(input int k, input string tag);
        chk({tag, "_sclk"}, int'(t_sclk[k]), 0);
        chk({tag, "_mosi"}, int'(t_mosi[k]), 0);
        chk({tag, "_done"}, int'(t_done[k]), 1);
        chk({tag, "_rx"},   int'(t_rx[k]),   0);
    endtask

    // Called with txn_done already seen low; pops the expectation when the byte completes.
    task automatic finish_txn(input int k, input int r0);
        int   busy;
        exp_t e;
        busy = 1;
        while (t_done[k] === 1'b0 && busy < 2000) begin
            tick();
            if (t_done[k] === 1'b0) busy++;
        end
        e = sb_q.pop_front();
        chk("busy_cycles", busy, e.busy);
        chk("data_rx", int'(t_rx[k]), int'(e.rx));
        chk("mosi_bits", int'(s_cap[k]), int'(e.mosi));
        chk("sclk_high_cycles", s_high[k], e.high);
        chk("sclk_rises", tot_rises[k] - r0, 8);
        $display("txn dut%0d: tx=%02h rx=%02h busy=%0d", k, s_cap[k], t_rx[k], busy);
    endtask

    task automatic run_txn(input int k, input logic [7:0] tx, input logic [7:0] slv,
                           input int div, input logic frc);
        int r0;
        r0 = tot_rises[k];
        sb_q.push_back('{rx: slv, mosi: tx, busy: 16 * div, high: 8 * div});
        s_byte[k] = slv; t_tx[k] = tx; t_start[k] = 1'b1; t_force[k] = frc;
        tick();
        t_start[k] = 1'b0; t_force[k] = 1'b0;
        chk("ack_done", int'(t_done[k]), 0);
        chk("ack_mosi", int'(t_mosi[k]), int'(tx[7]));
        if (t_done[k] === 1'b0) finish_txn(k, r0);
        else void'(sb_q.pop_back());
    endtask

    task automatic run_force(input int k, input int div);
        int   hi, busy_seen, r0;
        logic m0;
        hi = 0; busy_seen = 0; r0 = tot_rises[k]; m0 = t_mosi[k];
        t_force[k] = 1'b1;
        tick();
        t_force[k] = 1'b0;
        for (int i = 0; i < 2 * div + 2; i++) begin
            if (t_sclk[k] === 1'b1) hi++;
            if (t_done[k] !== 1'b1) busy_seen++;
            tick();
        end
        chk("force_high_cycles", hi, div);
        chk("force_done_low", busy_seen, 0);
        chk("force_mosi_hold", int'(t_mosi[k]), int'(m0));
        chk("force_rises", tot_rises[k] - r0, 1);
        $display("force dut%0d: high=%0d rises=%0d", k, hi, tot_rises[k] - r0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits, r0;
        vecs[0] = '{tx: 8'h03, slv: 8'hA5, frc: 1'b0};
        vecs[1] = '{tx: 8'hFF, slv: 8'h00, frc: 1'b0};
        vecs[2] = '{tx: 8'h00, slv: 8'hFF, frc: 1'b0};
        vecs[3] = '{tx: 8'h81, slv: 8'h7E, frc: 1'b0};
        vecs[4] = '{tx: 8'hC3, slv: 8'h3C, frc: 1'b1};
        vecs[5] = '{tx: 8'h5A, slv: 8'h96, frc: 1'b0};
        for (int k = 0; k < 2; k++) begin
            t_start[k] = 1'b0; t_force[k] = 1'b0; t_tx[k] = 8'h00;
        end

        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_vals(0, "reset_d1");
        check_reset_vals(1, "reset_d3");
        rst_n = 1'b1;
        tick();

        // Back-to-back bytes: each start is raised in the cycle txn_done returns high.
        for (int v = 0; v < 6; v++) run_txn(0, vecs[v].tx, vecs[v].slv, 1, vecs[v].frc);

        run_txn(1, 8'hFF, 8'h5A, 3, 1'b0);
        run_force(0, 1);
        run_force(1, 3);

        // Start raised during a force pulse is accepted in the first IDLE cycle after it.
        r0 = tot_rises[0];
        t_force[0] = 1'b1;
        tick();
        t_force[0] = 1'b0;
        sb_q.push_back('{rx: 8'h69, mosi: 8'h96, busy: 16, high: 8});
        s_byte[0] = 8'h69; t_tx[0] = 8'h96; t_start[0] = 1'b1;
        waits = 0;
        while (t_done[0] === 1'b1 && waits < 100) begin
            tick();
            waits++;
        end
        t_start[0] = 1'b0;
        chk("overlap_accept_wait", waits, 3);
        chk("overlap_mosi", int'(t_mosi[0]), 1);
        if (t_done[0] === 1'b0) finish_txn(0, r0 + 1);
        else void'(sb_q.pop_back());

        // Reset after the 4th SCLK rise, then a clean byte.
        sb_q.push_back('{rx: 8'h00, mosi: 8'hFF, busy: 16, high: 8});
        s_byte[0] = 8'hC3; t_tx[0] = 8'hFF; t_start[0] = 1'b1;
        tick();
        t_start[0] = 1'b0;
        waits = 0;
        while (s_rises[0] < 4 && waits < 100) begin
            tick();
            waits++;
        end
        chk("rst_mid_rises", s_rises[0], 4);
        chk("rst_mid_busy", int'(t_done[0]), 0);
        rst_n = 1'b0;
        tick();
        void'(sb_q.pop_back());
        check_reset_vals(0, "rst_mid");
        rst_n = 1'b1;
        tick();
        run_txn(0, 8'h5A, 8'h3C, 1, 1'b0);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
